// File: rtl/mem_retire_scheduler_pkg.sv
// Shared types for the retire scheduler: retire-port struct, RAM base, FSM states.
package mem_retire_scheduler_pkg;

  localparam logic [31:0] RAM_BASE = 32'h1001_0000;

  typedef struct packed {
    logic        store_ready;
    logic [31:0] mem_address;
  } retire_store_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FLUSH_WAIT = 2'd1,
    FLUSH      = 2'd2
  } sched_state_e;

endpackage

// File: rtl/mem_retire_scheduler_retire_fifo.sv
// Circular FIFO with combinational head; pushes refused when full, pops ignored when empty.
module retire_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap without compare logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_retire_scheduler.sv
// Queues committed stores and drains one per cycle to the retire port (2-cycle min latency);
// commits are refused when full or while a flush is pending; flush fires only once the queue is drained.
module mem_retire_scheduler #(
  parameter int          DEPTH      = 4,
  parameter int          ADDR_WIDTH = 7,
  parameter logic [31:0] RAM_BASE   = mem_retire_scheduler_pkg::RAM_BASE
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   commit_valid,
  input  logic [31:0]                            commit_address,
  output logic                                   commit_ready,
  input  logic                                   drain_en,
  input  logic                                   flush_req,
  output mem_retire_scheduler_pkg::retire_store_t retire_store,
  output logic                                   flush_out,
  output logic                                   flush_done,
  output logic                                   oor_err,
  output logic [$clog2(DEPTH+1)-1:0]             count
);

  import mem_retire_scheduler_pkg::*;

  localparam logic [32:0] RAM_BYTES = 33'd4 << ADDR_WIDTH;

  sched_state_e state;
  logic [31:0]  head_addr;
  logic [31:0]  head_offset;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         in_range;

  assign commit_ready = !full && (state == IDLE);
  assign push         = commit_valid && commit_ready;
  assign pop          = drain_en && !empty;

  // Unsigned wrap-around makes addresses below the base land out of range too.
  assign head_offset  = head_addr - RAM_BASE;
  assign in_range     = ({1'b0, head_offset} < RAM_BYTES);

  retire_fifo #(
    .DEPTH (DEPTH),
    .DW    (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (commit_address),
    .pop       (pop),
    .pop_data  (head_addr),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_store <= '0;
      oor_err      <= 1'b0;
    end else begin
      retire_store.store_ready <= pop && in_range;
      oor_err                  <= pop && !in_range;
      if (pop) retire_store.mem_address <= head_addr;
    end
  end

  // Waiting on store_ready too keeps the last retired write ahead of the flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:       if (flush_req) state <= FLUSH_WAIT;
        FLUSH_WAIT: if (empty && !retire_store.store_ready) state <= FLUSH;
        FLUSH:      state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  assign flush_out  = (state == FLUSH);
  assign flush_done = (state == FLUSH);

endmodule

// File: tb/tb_mem_retire_scheduler.sv
// Scoreboard bench for mem_retire_scheduler: expected stores queued at commit, checked at drain.
module tb_mem_retire_scheduler;
  import mem_retire_scheduler_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          commit_valid;
  logic [31:0]   commit_address;
  logic          commit_ready;
  logic          drain_en;
  logic          flush_req;
  retire_store_t retire_store;
  logic          flush_out;
  logic          flush_done;
  logic          oor_err;
  logic [2:0]    count;

  typedef struct packed {
    logic        oor;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   oor_seen = 0;
  int   flush_seen = 0;

  mem_retire_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .commit_valid   (commit_valid),
    .commit_address (commit_address),
    .commit_ready   (commit_ready),
    .drain_en       (drain_en),
    .flush_req      (flush_req),
    .retire_store   (retire_store),
    .flush_out      (flush_out),
    .flush_done     (flush_done),
    .oor_err        (oor_err),
    .count          (count)
  );

  always #5 clk = ~clk;

  // RAM window for the default parameters: 0x1001_0000 .. 0x1001_01FF.
  function automatic logic is_oor(input logic [31:0] a);
    return !((a >= 32'h1001_0000) && (a <= 32'h1001_01FF));
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (retire_store.store_ready || oor_err) begin
        exp_t e;
        n_checks++;
        if (oor_err) oor_seen++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_drain addr=%h ready=%b oor=%b", retire_store.mem_address,
                   retire_store.store_ready, oor_err);
        end else begin
          e = sb.pop_front();
          if (retire_store.mem_address !== e.addr || retire_store.store_ready !== !e.oor ||
              oor_err !== e.oor) begin
            n_fail++;
            $display("FAIL drain_order got addr=%h ready=%b oor=%b want addr=%h ready=%b oor=%b",
                     retire_store.mem_address, retire_store.store_ready, oor_err,
                     e.addr, !e.oor, e.oor);
          end
        end
      end
      if (flush_out || flush_done) begin
        flush_seen++;
        n_checks++;
        if (flush_out !== flush_done || retire_store.store_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_pulse got out=%b done=%b ready=%b want out=1 done=1 ready=0",
                   flush_out, flush_done, retire_store.store_ready);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_commit(input logic [31:0] a, input logic accept);
    exp_t e;
    commit_valid   = 1'b1;
    commit_address = a;
    n_checks++;
    if (commit_ready !== accept) begin
      n_fail++;
      $display("FAIL commit_ready addr=%h got %b want %b", a, commit_ready, accept);
    end
    if (accept) begin
      e.oor  = is_oor(a);
      e.addr = a;
      sb.push_back(e);
    end
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; commit_valid = 1'b0; commit_address = '0; drain_en = 1'b0; flush_req = 1'b0;
    #3;
    n_checks++;
    if (retire_store !== '0 || oor_err !== 1'b0 || flush_out !== 1'b0 || flush_done !== 1'b0 ||
        count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state got rs=%h oor=%b fo=%b fd=%b cnt=%0d want all 0",
               retire_store, oor_err, flush_out, flush_done, count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (commit_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset got %b want 1", commit_ready);
    end
  endtask

  task automatic test_single_store();
    drain_en = 1'b1;
    drive_commit(32'h1001_0008, 1'b1);
    n_checks++;
    if (count !== 3'd1 || retire_store.store_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_n1 got cnt=%0d ready=%b want cnt=1 ready=0", count, retire_store.store_ready);
    end
    tick();
    n_checks++;
    if (retire_store.store_ready !== 1'b1 || retire_store.mem_address !== 32'h1001_0008 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_n2 got ready=%b addr=%h cnt=%0d want ready=1 addr=10010008 cnt=0",
               retire_store.store_ready, retire_store.mem_address, count);
    end
    tick();
    n_checks++;
    if (retire_store.store_ready !== 1'b0 || retire_store.mem_address !== 32'h1001_0008) begin
      n_fail++;
      $display("FAIL single_n3 got ready=%b addr=%h want ready=0 addr=10010008",
               retire_store.store_ready, retire_store.mem_address);
    end
  endtask

  task automatic test_fill_stall();
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) drive_commit(32'h1001_0000 + 32'(4 * i), 1'b1);
    drive_commit(32'h1001_0010, 1'b0);
    n_checks++;
    if (count !== 3'd4 || commit_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full got cnt=%0d ready=%b want cnt=4 ready=0", count, commit_ready);
    end
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (retire_store.store_ready !== 1'b1 || count !== 3'(3 - i)) begin
        n_fail++;
        $display("FAIL fill_drain%0d got ready=%b cnt=%0d want ready=1 cnt=%0d",
                 i, retire_store.store_ready, count, 3 - i);
      end
    end
    tick();
    n_checks++;
    if (retire_store.store_ready !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL fill_done got ready=%b pending=%0d want ready=0 pending=0",
               retire_store.store_ready, sb.size());
    end
  endtask

  task automatic test_out_of_range();
    int oor_start;
    oor_start = oor_seen;
    drain_en  = 1'b1;
    drive_commit(32'h1001_01FC, 1'b1);
    drive_commit(32'h1001_0200, 1'b1);
    drive_commit(32'h0000_0100, 1'b1);
    repeat (3) tick();
    n_checks++;
    if (oor_seen - oor_start != 2 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL oor_count got %0d pending=%0d want 2 pending=0", oor_seen - oor_start, sb.size());
    end
  endtask

  task automatic test_flush_order();
    drain_en = 1'b0;
    drive_commit(32'h1001_0010, 1'b1);
    flush_req = 1'b1;
    drive_commit(32'h1001_0014, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (flush_out !== 1'b0 || commit_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_hold%0d got fo=%b ready=%b want fo=0 ready=0", i, flush_out, commit_ready);
      end
      tick();
    end
    drain_en = 1'b1;
    tick();
    tick();
    n_checks++;
    if (retire_store.store_ready !== 1'b1 || flush_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_second_store got ready=%b fo=%b want ready=1 fo=0", retire_store.store_ready, flush_out);
    end
    tick();
    n_checks++;
    if (retire_store.store_ready !== 1'b0 || flush_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_gap got ready=%b fo=%b want ready=0 fo=0", retire_store.store_ready, flush_out);
    end
    tick();
    n_checks++;
    if (flush_out !== 1'b1 || flush_done !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_fire got fo=%b fd=%b want fo=1 fd=1", flush_out, flush_done);
    end
    flush_req = 1'b0;
    tick();
    n_checks++;
    if (flush_out !== 1'b0 || commit_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle got fo=%b ready=%b want fo=0 ready=1", flush_out, commit_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] want;
    want = 5'b10010;
    flush_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (flush_out !== want[i]) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d got fo=%b want fo=%b", i, flush_out, want[i]);
      end
    end
    flush_req = 1'b0;
    tick();
    n_checks++;
    if (flush_out !== 1'b0 || commit_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle got fo=%b ready=%b want fo=0 ready=1", flush_out, commit_ready);
    end
  endtask

  task automatic test_wrap();
    drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_commit(32'h1001_0020 + 32'(4 * i), 1'b1);
      n_checks++;
      if (count !== 3'd1) begin
        n_fail++;
        $display("FAIL wrap_count%0d got %0d want 1", i, count);
      end
    end
    tick();
    tick();
    n_checks++;
    if (count !== 3'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_done got cnt=%0d pending=%0d want cnt=0 pending=0", count, sb.size());
    end
  endtask

  task automatic test_reset_mid_flush();
    int flush_start;
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) drive_commit(32'h1001_0040 + 32'(4 * i), 1'b0 | 1'b1);
    // These entries are discarded by the reset, so drop them from the scoreboard.
    for (int i = 0; i < 3; i++) void'(sb.pop_back());
    flush_req = 1'b1;
    tick();
    tick();
    flush_start = flush_seen;
    rst_n     = 1'b0;
    flush_req = 1'b0;
    #2;
    n_checks++;
    if (retire_store !== '0 || oor_err !== 1'b0 || flush_out !== 1'b0 || flush_done !== 1'b0 ||
        count !== 3'd0) begin
      n_fail++;
      $display("FAIL midreset_state got rs=%h oor=%b fo=%b fd=%b cnt=%0d want all 0",
               retire_store, oor_err, flush_out, flush_done, count);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    drain_en = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (flush_seen != flush_start || count !== 3'd0 || commit_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_after got flushes=%0d cnt=%0d ready=%b want flushes=0 cnt=0 ready=1",
               flush_seen - flush_start, count, commit_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_fill_stall();
    test_out_of_range();
    test_flush_order();
    test_back_to_back();
    test_wrap();
    test_reset_mid_flush();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_retire_scheduler.md
Name: mem_retire_scheduler

Overview:
- Buffers stores committed by the ROB and drains them one per cycle into the write-cache/RAM retire port of the memory execution unit (store_ready plus mem_address).
- Sequences pipeline flush so that a flush never discards a retired store still sitting only in the write cache.
- Sits between ROB commit and mem_exec_unit. It owns the retire_store driver and the flush signal into the memory execution unit.

Parameters:
- DEPTH, 4, retired-store queue entries; must be a power of two, at least 2.
- ADDR_WIDTH, 7, RAM word-address width; the RAM window is RAM_BASE .. RAM_BASE + 4*2^ADDR_WIDTH - 1.
- RAM_BASE, 32'h1001_0000, byte base address of data RAM.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- commit_valid  in  1  ROB retires a store this cycle.
- commit_address  in  32  byte address of the retiring store (rs1 + imm).
- commit_ready  out  1  queue can accept a commit this cycle.
- drain_en  in  1  memory side permits a store write this cycle.
- flush_req  in  1  mispredict flush request; level, held until flush_done.
- retire_store  out  struct  {store_ready 1, mem_address 32}; registered.
- flush_out  out  1  one-cycle flush pulse to mem_exec_unit and the issue queues.
- flush_done  out  1  one-cycle pulse, same cycle as flush_out.
- oor_err  out  1  one-cycle pulse: the drained entry was outside the RAM window.
- count  out  $clog2(DEPTH+1)  queue occupancy.

Behaviour:
- Reset values: all outputs 0, pointers 0, count 0, state IDLE.
- Queue:
  - Circular FIFO with wr_ptr and rd_ptr, each $clog2(DEPTH) bits; both wrap naturally modulo DEPTH.
  - Push when commit_valid && commit_ready.
  - commit_ready = (count != DEPTH) && (state == IDLE). A commit_valid while commit_ready = 0 is dropped; the ROB must hold it.
  - A push and a pop in the same cycle leave count unchanged.
  - When full, a push is refused even if a pop happens in the same cycle.
- Drain:
  - Pop when count != 0 && drain_en. The popped entry is registered into retire_store on the next edge.
  - In-range entry (address - RAM_BASE, unsigned 32-bit, < 4*2^ADDR_WIDTH): store_ready = 1 for exactly one cycle and mem_address = the entry address.
  - Out-of-range entry: store_ready stays 0, mem_address is updated anyway, and oor_err pulses 1.
  - Without a pop, store_ready = 0 and mem_address holds its value.
  - Maximum throughput is one store per cycle.
  - Latency: a commit in cycle N reaches store_ready at the end of cycle N+1 at the earliest (store_ready high in cycle N+2) when the queue is empty and drain_en = 1.
  - Stores leave in commit order.
- FSM:
  - IDLE: flush_req = 1 → FLUSH_WAIT. A commit in the same cycle as a rising flush_req is still accepted.
  - FLUSH_WAIT: pushes blocked; draining continues. When count == 0 && store_ready == 0 → FLUSH.
  - FLUSH: flush_out = 1 and flush_done = 1 for this single cycle, then → IDLE.
  - flush_req still high on return to IDLE starts a new flush sequence (back-to-back flushes allowed).
  - flush_out is a Moore output of state FLUSH. It never coincides with store_ready.
  - In FLUSH_WAIT with drain_en held 0, the FSM waits indefinitely; there is no timeout.
- Async reset mid-operation: queue contents are discarded, the FSM returns to IDLE, and no flush_out is generated.

Decomposition:
- Shared package (utils.sv):
  - retire_store typedef, reused unchanged.
  - RAM_BASE constant.
  - New typedef sched_state_e {IDLE, FLUSH_WAIT, FLUSH}.
- One sub-module: retire_fifo, a parameterised circular FIFO (push/pop/full/empty/count, 32-bit data).
- The FSM and range check stay in the top module.

Test Plan:
- Single store: commit 0x1001_0008 with queue empty and drain_en = 1 → two cycles later store_ready = 1 for one cycle with mem_address = 0x1001_0008; count returns to 0.
- Fill and stall: drain_en = 0, commit 0x1001_0000/04/08/0C → count = 4, commit_ready = 0, a fifth commit of 0x1001_0010 is dropped. Then drain_en = 1 → four consecutive store_ready pulses in order 00, 04, 08, 0C, and no 0x10.
- Out of range: commit 0x1001_0200 (first address beyond the RAM window) and 0x0000_0100 → store_ready stays 0, oor_err pulses twice, mem_address shows each address in turn.
- Flush ordering: two stores queued, drain_en = 0, flush_req = 1 for 5 cycles → no flush_out and commit_ready = 0. Then drain_en = 1 → two store_ready pulses, one idle cycle, then flush_out = flush_done = 1 for exactly one cycle, then back in IDLE.
- Pointer wrap: 10 commits with a pop every cycle → addresses emerge in order, count never exceeds 2, and simultaneous push/pop keeps count stable.
- Reset mid-flush: in FLUSH_WAIT with 3 entries queued, pulse rst_n low → all outputs 0, count = 0, and no flush_out is produced afterwards.
